bfly_stage: RTL and testbench

Parametrised multi-lane radix-2 DIF butterfly stage for the FFT datapath. It accepts NUM parallel complex samples per beat and buffers the first half of each frame in an internal delay buffer. It pairs each second-half beat with the buffered beat from the same lane and emits sum and difference outputs. Compared with the previous fixed 16-lane/512-point stage, it tolerates gaps in `valid_in`, resynchronises on `sync_in`, flags broken frames, and optionally scales its outputs.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/bfly_stage_if.sv | 39 +++
 rtl/bfly_stage_delay_buf.sv | 43 ++++
 rtl/bfly_stage.sv | 192 +++++++++++++++++++
 tb/tb_bfly_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared types, default constants and helpers for the FFT
//             datapath (butterfly stages and their delay buffers).
//  Contents : FFT_DATA / FFT_NUM / FFT_IN_WIDTH default constants,
//             cplx_t (re/im pair at FFT_IN_WIDTH), sext() sign extension.
//  Revision : 1.0 - multi-lane butterfly stage support
// ============================================================================
package fft_pkg;

  localparam int FFT_DATA     = 512;
  localparam int FFT_NUM      = 16;
  localparam int FFT_IN_WIDTH = 9;

  typedef struct packed {
    logic signed [FFT_IN_WIDTH-1:0] re;
    logic signed [FFT_IN_WIDTH-1:0] im;
  } cplx_t;

  // Sign-extends the low w bits of x to a full 32-bit signed value.
  // Callers cast the result down to the width they need.
  function automatic logic signed [31:0] sext(input logic [31:0] x, input int w);
    logic signed [31:0] v;
    v = $signed(x << (32 - w));
    return v >>> (32 - w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bfly_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : bfly_stage_if
//  Purpose  : Beat-level bus of the butterfly stage: input beat (valid, sync,
//             NUM complex lanes) and output pair (sum, difference, flags).
//  Modports : master - drives input beats, observes results (source side)
//             slave  - receives input beats, drives results (stage side)
//  Revision : 1.0 - multi-lane butterfly stage support
// ============================================================================
interface bfly_stage_if #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = IN_WIDTH + 1,
  parameter int NUM       = 16
);

  logic                                      valid_in;
  logic                                      sync_in;
  logic signed [NUM-1:0][IN_WIDTH-1:0]       din_re;
  logic signed [NUM-1:0][IN_WIDTH-1:0]       din_im;
  logic signed [NUM-1:0][OUT_WIDTH-1:0]      do1_re;
  logic signed [NUM-1:0][OUT_WIDTH-1:0]      do1_im;
  logic signed [NUM-1:0][OUT_WIDTH-1:0]      do2_re;
  logic signed [NUM-1:0][OUT_WIDTH-1:0]      do2_im;
  logic                                      valid_out;
  logic                                      last_out;
  logic                                      frame_err;

  modport master (
    output valid_in, sync_in, din_re, din_im,
    input  do1_re, do1_im, do2_re, do2_im, valid_out, last_out, frame_err
  );

  modport slave (
    input  valid_in, sync_in, din_re, din_im,
    output do1_re, do1_im, do2_re, do2_im, valid_out, last_out, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/bfly_stage_delay_buf.sv
`default_nettype none
// ============================================================================
//  Module   : bfly_delay_buf
//  Purpose  : HALF-deep buffer holding the first-half beats of a frame, one
//             {re, im} word per lane. Synchronous write, combinational read.
//  Ports    : clk   - clock
//             we    - write enable
//             waddr - write slot
//             wdata - NUM lanes of {re, im}
//             raddr - read slot
//             rdata - NUM lanes of {re, im} at raddr
//  Revision : 1.0 - multi-lane butterfly stage support
// ============================================================================
module bfly_delay_buf
  import fft_pkg::*;
#(
  parameter int NUM      = FFT_NUM,
  parameter int IN_WIDTH = FFT_IN_WIDTH,
  parameter int HALF     = 16,
  parameter int AW       = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [NUM-1:0][2*IN_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                  raddr,
  output logic [NUM-1:0][2*IN_WIDTH-1:0] rdata
);

  // No reset: a slot is always written in the fill half before the pair
  // half reads it, so stale contents never reach the outputs.
  logic [NUM-1:0][2*IN_WIDTH-1:0] r_mem [HALF];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/bfly_stage.sv
`default_nettype none
// ============================================================================
//  Module   : bfly_stage
//  Purpose  : Multi-lane radix-2 DIF butterfly stage. First half of each
//             frame is buffered; each second-half beat is paired with the
//             buffered beat of the same lane and emits a+b / a-b one cycle
//             later. Tolerates valid gaps, resynchronises on sync_in and
//             flags early restarts on frame_err.
//  Ports    : clk  - clock
//             rstn - asynchronous active-low reset
//             bus  - bfly_stage_if.slave (valid_in, sync_in, din_re/im,
//                    do1_re/im, do2_re/im, valid_out, last_out, frame_err)
//  Config   : BFLY_STAGE_SCALE_EN - when defined, every result is
//             (x + 1) >>> 1 (round-half-up), same latency.
//  Revision : 1.0 - multi-lane butterfly stage support
// ============================================================================
module bfly_stage
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = FFT_IN_WIDTH,
  parameter int OUT_WIDTH = IN_WIDTH + 1,
  parameter int NUM       = FFT_NUM,
  parameter int DATA      = FFT_DATA
) (
  input logic         clk,
  input logic         rstn,
  bfly_stage_if.slave bus
);

  localparam int COUNT = DATA / NUM;
  localparam int HALF  = COUNT / 2;
  localparam int CW    = $clog2(COUNT);
  localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LW    = 2 * IN_WIDTH;

  // --------------------------------------------------------------------------
  // Arithmetic helpers
  // --------------------------------------------------------------------------
  // Sign-extends the low w bits of v to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] ext_out(input logic [IN_WIDTH:0] v,
                                                         input int w);
    logic signed [31:0] t;
    t = sext({{(31 - IN_WIDTH){1'b0}}, v}, w);
    return OUT_WIDTH'(t);
  endfunction

  // One butterfly output: a+b (sub=0) or a-b (sub=1).
  function automatic logic signed [OUT_WIDTH-1:0] bfly_op(input logic signed [IN_WIDTH-1:0] a,
                                                         input logic signed [IN_WIDTH-1:0] b,
                                                         input logic sub);
`ifdef BFLY_STAGE_SCALE_EN
    logic signed [IN_WIDTH:0]   s;
    logic signed [IN_WIDTH+1:0] r;
    s = sub ? ({a[IN_WIDTH-1], a} - {b[IN_WIDTH-1], b})
            : ({a[IN_WIDTH-1], a} + {b[IN_WIDTH-1], b});
    // One guard bit so that s + 1 cannot wrap when s is the largest
    // difference; the halved result always fits in IN_WIDTH+1 bits.
    r = $signed({s[IN_WIDTH], s} + (IN_WIDTH + 2)'(1)) >>> 1;
    return ext_out((IN_WIDTH + 1)'(r), IN_WIDTH + 1);
`else
    logic signed [OUT_WIDTH-1:0] ea;
    logic signed [OUT_WIDTH-1:0] eb;
    ea = ext_out({1'b0, a}, IN_WIDTH);
    eb = ext_out({1'b0, b}, IN_WIDTH);
    return sub ? (ea - eb) : (ea + eb);
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Beat counter and sync handling
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_eff_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_restart;
  logic          w_is_pair;
  logic          w_is_last;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;

  always_comb begin
    w_restart = 1'b0;
    w_eff_cnt = r_cnt;
    w_is_pair = 1'b0;
    w_is_last = 1'b0;
    w_we      = 1'b0;
    w_cnt_nxt = r_cnt;
    if (bus.valid_in) begin
      // A sync beat mid-frame is re-interpreted as beat 0 of a new frame.
      w_restart = bus.sync_in && (r_cnt != '0);
      w_eff_cnt = w_restart ? '0 : r_cnt;
      w_is_pair = (w_eff_cnt >= CW'(HALF));
      w_is_last = w_is_pair && (w_eff_cnt == CW'(COUNT - 1));
      w_we      = !w_is_pair;
      w_cnt_nxt = w_is_last ? '0 : (w_eff_cnt + CW'(1));
    end
  end

  // Fill writes slot cnt; pair reads slot cnt-HALF. They never collide since
  // a beat is either in the fill half or the pair half.
  assign w_waddr = AW'(w_eff_cnt);
  assign w_raddr = AW'(r_cnt - CW'(HALF));

  // --------------------------------------------------------------------------
  // Delay buffer
  // --------------------------------------------------------------------------
  logic [NUM-1:0][LW-1:0] w_wdata;
  logic [NUM-1:0][LW-1:0] w_rdata;

  bfly_delay_buf #(
    .NUM      (NUM),
    .IN_WIDTH (IN_WIDTH),
    .HALF     (HALF),
    .AW       (AW)
  ) u_delay_buf (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Per-lane butterflies
  // --------------------------------------------------------------------------
  logic [NUM-1:0][OUT_WIDTH-1:0] w_s_re;
  logic [NUM-1:0][OUT_WIDTH-1:0] w_s_im;
  logic [NUM-1:0][OUT_WIDTH-1:0] w_d_re;
  logic [NUM-1:0][OUT_WIDTH-1:0] w_d_im;

  for (genvar k = 0; k < NUM; k++) begin : g_lane
    logic signed [IN_WIDTH-1:0] w_a_re;
    logic signed [IN_WIDTH-1:0] w_a_im;

    assign w_wdata[k] = {bus.din_re[k], bus.din_im[k]};
    assign w_a_re     = w_rdata[k][LW-1:IN_WIDTH];
    assign w_a_im     = w_rdata[k][IN_WIDTH-1:0];

    assign w_s_re[k] = bfly_op(w_a_re, bus.din_re[k], 1'b0);
    assign w_d_re[k] = bfly_op(w_a_re, bus.din_re[k], 1'b1);
    assign w_s_im[k] = bfly_op(w_a_im, bus.din_im[k], 1'b0);
    assign w_d_im[k] = bfly_op(w_a_im, bus.din_im[k], 1'b1);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  logic [NUM-1:0][OUT_WIDTH-1:0] r_do1_re;
  logic [NUM-1:0][OUT_WIDTH-1:0] r_do1_im;
  logic [NUM-1:0][OUT_WIDTH-1:0] r_do2_re;
  logic [NUM-1:0][OUT_WIDTH-1:0] r_do2_im;
  logic                          r_valid_out;
  logic                          r_last_out;
  logic                          r_frame_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
      r_frame_err <= 1'b0;
      r_do1_re    <= '0;
      r_do1_im    <= '0;
      r_do2_re    <= '0;
      r_do2_im    <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_valid_out <= w_is_pair;
      r_last_out  <= w_is_last;
      r_frame_err <= w_restart;
      // Data is held between pairs; only valid_out drops.
      if (w_is_pair) begin
        r_do1_re <= w_s_re;
        r_do1_im <= w_s_im;
        r_do2_re <= w_d_re;
        r_do2_im <= w_d_im;
      end
    end
  end

  assign bus.do1_re    = r_do1_re;
  assign bus.do1_im    = r_do1_im;
  assign bus.do2_re    = r_do2_re;
  assign bus.do2_im    = r_do2_im;
  assign bus.valid_out = r_valid_out;
  assign bus.last_out  = r_last_out;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_bfly_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bfly_stage
//  Purpose  : Scoreboard bench for bfly_stage. The stimulus process pushes the
//             expected pair (values, last flag, arrival cycle) for every
//             second-half beat; a monitor pops and compares on valid_out and
//             on frame_err.
//  Config   : BFLY_STAGE_SCALE_EN selects the halved/rounded expectations.
//  Revision : 1.0 - multi-lane butterfly stage support
// ============================================================================
module tb_bfly_stage;
  import fft_pkg::*;

  localparam int IW    = FFT_IN_WIDTH;
  localparam int OW    = IW + 1;
  localparam int NUM   = FFT_NUM;
  localparam int DATA  = FFT_DATA;
  localparam int COUNT = DATA / NUM;
  localparam int HALF  = COUNT / 2;
  localparam int VW    = NUM * OW;

  typedef struct packed {
    int            cyc;
    logic          last;
    logic [VW-1:0] d1r;
    logic [VW-1:0] d1i;
    logic [VW-1:0] d2r;
    logic [VW-1:0] d2i;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   err_q[$];
  exp_t last_pushed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bfly_stage_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(NUM)) bus ();

  bfly_stage #(
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .NUM       (NUM),
    .DATA      (DATA)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // --------------------------------------------------------------------------
  // Stimulus patterns (beat j, lane k) and expected butterfly arithmetic
  //   0: re=j, im=-k
  //   1: full scale: first half re=255 im=-256, second half re=255 im=255
  //   2: small: first half re=3 im=-3, second half re=2 im=0
  //   3: filler: re=100+j+k, im=k-50
  // --------------------------------------------------------------------------
  function automatic int val_re(input int kind, input int j, input int k);
    case (kind)
      0:       return j;
      1:       return 255;
      2:       return (j < HALF) ? 3 : 2;
      default: return 100 + j + k;
    endcase
  endfunction

  function automatic int val_im(input int kind, input int j, input int k);
    case (kind)
      0:       return -k;
      1:       return (j < HALF) ? -256 : 255;
      2:       return (j < HALF) ? -3 : 0;
      default: return k - 50;
    endcase
  endfunction

  function automatic int bf(input int a, input int b, input bit sub);
    int r;
    r = sub ? (a - b) : (a + b);
`ifdef BFLY_STAGE_SCALE_EN
    r = (r + 1) >>> 1;
`endif
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Comparison helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [VW-1:0] act,
                      input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Drivers (called at a falling edge; return at the next falling edge)
  // --------------------------------------------------------------------------
  task automatic beat(input int kind, input int j, input bit sync);
    exp_t e;
    int   ar, ai, br, bi;
    bus.valid_in = 1'b1;
    bus.sync_in  = sync;
    for (int k = 0; k < NUM; k++) begin
      bus.din_re[k] = IW'(val_re(kind, j, k));
      bus.din_im[k] = IW'(val_im(kind, j, k));
    end
    if (j >= HALF) begin
      e.cyc  = cyc + 1;
      e.last = (j == COUNT - 1);
      for (int k = 0; k < NUM; k++) begin
        ar = val_re(kind, j - HALF, k);
        ai = val_im(kind, j - HALF, k);
        br = val_re(kind, j, k);
        bi = val_im(kind, j, k);
        e.d1r[k*OW +: OW] = OW'(bf(ar, br, 1'b0));
        e.d2r[k*OW +: OW] = OW'(bf(ar, br, 1'b1));
        e.d1i[k*OW +: OW] = OW'(bf(ai, bi, 1'b0));
        e.d2i[k*OW +: OW] = OW'(bf(ai, bi, 1'b1));
      end
      sb.push_back(e);
      last_pushed = e;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit sync);
    bus.valid_in = 1'b0;
    bus.sync_in  = sync;
    for (int k = 0; k < NUM; k++) begin
      bus.din_re[k] = IW'($urandom);
      bus.din_im[k] = IW'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic frame(input int kind, input bit sync0);
    for (int j = 0; j < COUNT; j++) beat(kind, j, sync0 && (j == 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid_out"}, 64'(bus.valid_out), 0);
    chk({tag, "_last_out"},  64'(bus.last_out),  0);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 0);
    chkv({tag, "_do1_re"}, bus.do1_re, '0);
    chkv({tag, "_do1_im"}, bus.do1_im, '0);
    chkv({tag, "_do2_re"}, bus.do2_re, '0);
    chkv({tag, "_do2_im"}, bus.do2_im, '0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (rstn) begin
      if (bus.frame_err) begin
        if (err_q.size() == 0) begin
          chk("frame_err_unexpected", 1, 0);
        end else begin
          ec = err_q.pop_front();
          chk("frame_err_cycle", cyc, ec);
        end
      end
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          chk("valid_out_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pair_cycle", cyc, e.cyc);
          chk("last_out", 64'(bus.last_out), 64'(e.last));
          chkv("do1_re", bus.do1_re, e.d1r);
          chkv("do1_im", bus.do1_im, e.d1i);
          chkv("do2_re", bus.do2_re, e.d2r);
          chkv("do2_im", bus.do2_im, e.d2i);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.valid_in = 1'b0;
    bus.sync_in  = 1'b0;
    bus.din_re   = '0;
    bus.din_im   = '0;
    rstn         = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Continuous frame: pair p -> do1_re=2p+16, do2_re=-16, do1_im=-2k, do2_im=0
    frame(0, 1'b1);
    repeat (3) idle(1'b0);

    // Gapped input; sync asserted on idle cycles must be ignored
    for (int j = 0; j < COUNT; j++) begin
      beat(0, j, j == 0);
      idle(1'b1);
    end
    repeat (2) idle(1'b0);

    // Back-to-back frames: plain, full scale, small values
    frame(0, 1'b1);
    frame(1, 1'b1);
    frame(2, 1'b1);
    repeat (3) idle(1'b0);

    // Early sync at beat 10 restarts the frame
    for (int j = 0; j < 10; j++) beat(3, j, j == 0);
    err_q.push_back(cyc + 1);
    frame(0, 1'b1);
    repeat (3) idle(1'b0);

    // Reset mid-frame at beat 20
    for (int j = 0; j < 20; j++) beat(3, j, j == 0);
    idle(1'b0);
    chk("hold_valid_out", 64'(bus.valid_out), 0);
    chkv("hold_do1_re", bus.do1_re, last_pushed.d1r);
    chkv("hold_do2_im", bus.do2_im, last_pushed.d2i);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    // First beat after release is beat 0 even without sync
    frame(0, 1'b0);
    repeat (3) idle(1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("pairs_outstanding", sb.size(), 0);
    chk("frame_err_outstanding", err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
